// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types, constants and FSM encodings.
// Imported by fp_classify and fp_div_seq.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int QBITS = MAN_W + 3;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] POS_INF =
        {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp_t;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIV,
        NORM,
        ROUND,
        DONE
    } div_state_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand decoder: IEEE class plus significand with hidden bit.
// Denormals are reported as ZERO (flush-to-zero).
module fp_classify
    import fp_pkg::*;
(
    input  fp_t            op_i,
    output fp_class_e      cls_o,
    output logic [MAN_W:0] sig_o
);

    always_comb begin
        cls_o = NORMAL;
        priority case (1'b1)
            op_i.exp == '0:   cls_o = ZERO;
            op_i.exp != '1:   cls_o = NORMAL;
            op_i.frac == '0:  cls_o = INF;
            default:          cls_o = NAN;
        endcase
    end

    assign sig_o = {(op_i.exp != '0), op_i.frac};

endmodule

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider, radix-2 restoring mantissa division.
// Build option FP_DIV_RNE_EN selects round-to-nearest-even; default truncates.
module fp_div_seq
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] opd1,
    input  logic [W-1:0] opd2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res,
    output logic         exp_overflow,
    output logic         nan,
    output logic         zero,
    output logic         div_by_zero
);

    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(QBITS + 1);

    typedef logic signed [EW-1:0] exp_t;

    localparam exp_t EXP_MAX = exp_t'((1 << EXP_W) - 1);
    localparam exp_t EXP_MIN = '0;

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    fp_t              a_q, a_d;
    fp_t              b_q, b_d;
    exp_t             exp_q, exp_d;
    logic [MAN_W+1:0] rem_q, rem_d;
    logic [QBITS-1:0] quo_q, quo_d;
    logic [MAN_W:0]   sig_q, sig_d;
`ifdef FP_DIV_RNE_EN
    logic             g_q, g_d;
    logic             st_q, st_d;
`endif
    logic [W-1:0]     res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             nan_q, nan_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    fp_t              op1, op2;
    fp_class_e        cls1, cls2;
    logic [MAN_W:0]   sig1, sig2;
    logic             sgn;
    logic             is_special;

    logic [W-1:0]     sp_res;
    logic             sp_nan, sp_zero, sp_dbz;

    logic             qbit;
    logic             inc;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W-1:0] frac_r;
    exp_t             exp_r;

    // Classify live inputs while idle, captured operands afterwards.
    assign op1 = (state_q == IDLE) ? fp_t'(opd1) : a_q;
    assign op2 = (state_q == IDLE) ? fp_t'(opd2) : b_q;

    fp_classify u_cls1 (
        .op_i  (op1),
        .cls_o (cls1),
        .sig_o (sig1)
    );

    fp_classify u_cls2 (
        .op_i  (op2),
        .cls_o (cls2),
        .sig_o (sig2)
    );

    assign sgn        = op1.sign ^ op2.sign;
    assign is_special = (cls1 != NORMAL) || (cls2 != NORMAL);

    always_comb begin
        sp_res  = {sgn, {(W-1){1'b0}}};
        sp_nan  = 1'b0;
        sp_zero = 1'b0;
        sp_dbz  = 1'b0;
        priority case (1'b1)
            (cls1 == NAN) || (cls2 == NAN) ||
            (cls1 == ZERO && cls2 == ZERO) ||
            (cls1 == INF && cls2 == INF): begin
                sp_res = QNAN;
                sp_nan = 1'b1;
            end
            cls1 == INF: begin
                sp_res = POS_INF | {sgn, {(W-1){1'b0}}};
            end
            cls2 == ZERO: begin
                sp_res = POS_INF | {sgn, {(W-1){1'b0}}};
                sp_dbz = 1'b1;
            end
            default: begin
                sp_zero = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        sig_d   = sig_q;
`ifdef FP_DIV_RNE_EN
        g_d     = g_q;
        st_d    = st_q;
`endif
        res_d   = res_q;
        ovf_d   = ovf_q;
        nan_d   = nan_q;
        zero_d  = zero_q;
        dbz_d   = dbz_q;
        qbit    = 1'b0;
        inc     = 1'b0;
        rnd     = '0;
        frac_r  = '0;
        exp_r   = exp_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = opd1;
                    b_d   = opd2;
                    cnt_d = '0;
                    if (is_special) begin
                        state_d = SPECIAL;
                    end else begin
                        state_d = DIV;
                        exp_d   = exp_t'({2'b00, op1.exp})
                                - exp_t'({2'b00, op2.exp})
                                + exp_t'(BIAS);
                        rem_d   = {1'b0, sig1};
                        quo_d   = '0;
                    end
                end
            end
            SPECIAL: begin
                // Two-cycle special path keeps done at a fixed offset.
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
                end else begin
                    state_d = DONE;
                    res_d   = sp_res;
                    ovf_d   = 1'b0;
                    nan_d   = sp_nan;
                    zero_d  = sp_zero;
                    dbz_d   = sp_dbz;
                end
            end
            DIV: begin
                qbit  = (rem_q >= {1'b0, sig2});
                rem_d = (qbit ? rem_q - {1'b0, sig2} : rem_q) << 1;
                quo_d = {quo_q[QBITS-2:0], qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(QBITS - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = ROUND;
                if (quo_q[QBITS-1]) begin
                    sig_d = quo_q[QBITS-1:2];
`ifdef FP_DIV_RNE_EN
                    g_d   = quo_q[1];
                    st_d  = quo_q[0] | (|rem_q);
`endif
                end else begin
                    sig_d = quo_q[QBITS-2:1];
                    exp_d = exp_q - exp_t'(1);
`ifdef FP_DIV_RNE_EN
                    g_d   = quo_q[0];
                    st_d  = |rem_q;
`endif
                end
            end
            ROUND: begin
`ifdef FP_DIV_RNE_EN
                inc = g_q & (st_q | sig_q[0]);
`else
                inc = 1'b0;
`endif
                rnd = {1'b0, sig_q} + {{(MAN_W+1){1'b0}}, inc};
                if (rnd[MAN_W+1]) begin
                    frac_r = rnd[MAN_W:1];
                    exp_r  = exp_q + exp_t'(1);
                end else begin
                    frac_r = rnd[MAN_W-1:0];
                end
                state_d = DONE;
                ovf_d   = 1'b0;
                nan_d   = 1'b0;
                zero_d  = 1'b0;
                dbz_d   = 1'b0;
                if (exp_r >= EXP_MAX) begin
                    res_d = POS_INF | {sgn, {(W-1){1'b0}}};
                    ovf_d = 1'b1;
                end else if (exp_r <= EXP_MIN) begin
                    res_d  = {sgn, {(W-1){1'b0}}};
                    zero_d = 1'b1;
                end else begin
                    res_d = {sgn, exp_r[EXP_W-1:0], frac_r};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            exp_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            sig_q   <= '0;
`ifdef FP_DIV_RNE_EN
            g_q     <= 1'b0;
            st_q    <= 1'b0;
`endif
            res_q   <= '0;
            ovf_q   <= 1'b0;
            nan_q   <= 1'b0;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            sig_q   <= sig_d;
`ifdef FP_DIV_RNE_EN
            g_q     <= g_d;
            st_q    <= st_d;
`endif
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            nan_q   <= nan_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign done         = (state_q == DONE);
    assign res          = res_q;
    assign exp_overflow = ovf_q;
    assign nan          = nan_q;
    assign zero         = zero_q;
    assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed cases, handshake corners,
// mid-operation reset, and random operands against an exact-arithmetic model.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] opd1, opd2;
    logic        busy, done;
    logic [31:0] res;
    logic        exp_overflow, nan, zero, div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp_div_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .opd1         (opd1),
        .opd2         (opd2),
        .busy         (busy),
        .done         (done),
        .res          (res),
        .exp_overflow (exp_overflow),
        .nan          (nan),
        .zero         (zero),
        .div_by_zero  (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {exp_overflow, nan, zero, div_by_zero};
    endfunction

    // 0 zero, 1 normal, 2 inf, 3 nan
    function automatic int cls(input logic [31:0] x);
        if (x[30:23] == 8'h00) return 0;
        if (x[30:23] != 8'hFF) return 1;
        if (x[22:0] == 23'h0) return 2;
        return 3;
    endfunction

    // Exact quotient via integer division; flags = {ovf, nan, zero, dbz}.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output bit sp);
        int     ca, cb, e;
        logic   s;
        longint m1, m2, q;
`ifdef FP_DIV_RNE_EN
        longint rm;
`endif
        ca = cls(a);
        cb = cls(b);
        s  = a[31] ^ b[31];
        f  = 4'b0000;
        sp = 1'b1;
        r  = 32'h0;
        if (ca == 3 || cb == 3 || (ca == 0 && cb == 0) || (ca == 2 && cb == 2)) begin
            r = 32'h7FC00000;
            f = 4'b0100;
        end else if (ca == 2) begin
            r = {s, 31'h7F800000};
        end else if (cb == 0) begin
            r = {s, 31'h7F800000};
            f = 4'b0001;
        end else if (ca == 0 || cb == 2) begin
            r = {s, 31'h0};
            f = 4'b0010;
        end else begin
            sp = 1'b0;
            m1 = longint'({1'b1, a[22:0]});
            m2 = longint'({1'b1, b[22:0]});
            e  = int'(a[30:23]) - int'(b[30:23]) + 127;
            if (m1 >= m2) begin
                q = (m1 << 23) / m2;
`ifdef FP_DIV_RNE_EN
                rm = (m1 << 23) % m2;
`endif
            end else begin
                q = (m1 << 24) / m2;
`ifdef FP_DIV_RNE_EN
                rm = (m1 << 24) % m2;
`endif
                e--;
            end
`ifdef FP_DIV_RNE_EN
            if (2 * rm > m2 || (2 * rm == m2 && q[0])) q++;
`endif
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e++;
            end
            if (e >= 255) begin
                r = {s, 31'h7F800000};
                f = 4'b1000;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 4'b0010;
            end else begin
                r = {s, 8'(e), 23'(q)};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        int          sel;
        logic [7:0]  e;
        logic [22:0] f;
        sel = int'($urandom_range(0, 19));
        f   = 23'($urandom);
        if (sel == 0) begin
            e = 8'h00;
        end else if (sel == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = 23'h0;
        end else if (sel < 4) begin
            e = 8'($urandom_range(1, 4));
        end else if (sel < 6) begin
            e = 8'($urandom_range(250, 254));
        end else begin
            e = 8'($urandom_range(1, 254));
        end
        return {1'($urandom), e, f};
    endfunction

    // Pulse start once, wait for done (bounded), return outputs and timing.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [3:0] f,
                          output int lat, output int busy_n);
        @(negedge clk);
        opd1  = a;
        opd2  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 60) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        r = res;
        f = flags_now();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] d_a   [6] = '{32'h40C00000, 32'h3F800000, 32'h3F800000,
                               32'h00000000, 32'h7F000000, 32'h00800000};
    logic [31:0] d_b   [6] = '{32'h40000000, 32'h40400000, 32'h00000000,
                               32'h00000000, 32'h3E800000, 32'h40000000};
`ifdef FP_DIV_RNE_EN
    logic [31:0] d_r   [6] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000,
                               32'h7FC00000, 32'h7F800000, 32'h00000000};
`else
    logic [31:0] d_r   [6] = '{32'h40400000, 32'h3EAAAAAA, 32'h7F800000,
                               32'h7FC00000, 32'h7F800000, 32'h00000000};
`endif
    logic [3:0]  d_f   [6] = '{4'b0000, 4'b0000, 4'b0001,
                               4'b0100, 4'b1000, 4'b0010};
    int          d_lat [6] = '{28, 28, 2, 2, 28, 28};

    initial begin
        logic [31:0] r, er;
        logic [3:0]  f, ef;
        bit          sp;
        int          lat, bn, dn;
        logic [31:0] a, b;

        rst_n = 1'b0;
        start = 1'b0;
        opd1  = 32'h0;
        opd2  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", res, 32'h0);
        check("rst_flags", 32'(flags_now()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(d_a[i], d_b[i], r, f, lat, bn);
            check($sformatf("dir%0d_res", i), r, d_r[i]);
            check($sformatf("dir%0d_flags", i), 32'(f), 32'(d_f[i]));
            check($sformatf("dir%0d_lat", i), 32'(lat), 32'(d_lat[i]));
            if (i == 0) check("dir0_busy_cycles", 32'(bn), 32'd28);
        end

        // start held high with different operands must not start a second op
        @(negedge clk);
        opd1  = 32'h40C00000;
        opd2  = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        opd1 = 32'h3F800000;
        opd2 = 32'h40400000;
        dn   = 0;
        r    = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                dn++;
                r = res;
            end
        end
        check("hold_dones", 32'(dn), 32'd1);
        check("hold_res", r, 32'h40400000);

        // reset in the middle of an operation
        @(negedge clk);
        opd1  = 32'h40C00000;
        opd2  = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_res", res, 32'h0);
        check("mid_rst_flags", 32'(flags_now()), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("mid_rst_no_done", 32'(dn), 32'd0);
        run_op(32'hC0C00000, 32'h40000000, r, f, lat, bn);
        check("post_rst_res", r, 32'hC0400000);
        check("post_rst_flags", 32'(f), 32'h0);

        for (int i = 0; i < 250; i++) begin
            a = rnd_op();
            b = rnd_op();
            model(a, b, er, ef, sp);
            run_op(a, b, r, f, lat, bn);
            check($sformatf("rnd%0d_res %h/%h", i, a, b), r, er);
            check($sformatf("rnd%0d_flags %h/%h", i, a, b), 32'(f), 32'(ef));
            check($sformatf("rnd%0d_lat", i), 32'(lat), sp ? 32'd2 : 32'd28);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
Sequential IEEE-754 single-precision divider, res = opd1 / opd2. It is the inverse-operation companion to fp_mult and shares its operand, result and flag conventions. It uses iterative radix-2 restoring mantissa division with a start/done handshake, and is driven by the same file-based golden-vector bench flow as fp_mult.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, fraction field width (word width = 1+EXP_W+MAN_W)
QBITS, MAN_W+3, quotient bits produced: 24 significand + 1 normalise + 1 guard

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
opd1  in  32  dividend, captured on the accept edge
opd2  in  32  divisor, captured on the accept edge
busy  out  1  high from accept until done
done  out  1  one-cycle pulse; res and flags valid from this cycle
res  out  32  quotient
exp_overflow  out  1  result overflowed to ±inf
nan  out  1  result is NaN
zero  out  1  result is ±0, including underflow flush
div_by_zero  out  1  finite nonzero / 0

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, res=0, all flags=0, counter=0. Any in-flight operation is discarded.
- States:
  - IDLE: start=1 accepts opd1/opd2. If the operands classify as special, next state is SPECIAL; otherwise next state is DIV.
  - SPECIAL: computes the result, then moves to DONE.
  - DIV: performs QBITS steps, one per cycle, then moves to NORM.
  - NORM: normalises, then moves to ROUND.
  - ROUND: rounds, then moves to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- Latency, with N = accept edge: done is high in the cycle after edge N+28 for normal operands and after edge N+2 for specials.
- start while busy or in DONE is ignored; the request is not queued.
- res and flags update only on entry to DONE and hold until the next DONE.
- Flags are mutually exclusive.
- Input classification (denormals flush to zero):
  - exp=0: zero.
  - exp=all-ones, frac=0: inf.
  - exp=all-ones, frac≠0: NaN.
- Sign = s1 XOR s2, applied to every non-NaN result.
- Specials, in priority order:
  1. NaN input, 0/0, or inf/inf: res=0x7FC00000, nan=1.
  2. inf/x: ±inf.
  3. x/0 with x finite nonzero: ±inf, div_by_zero=1.
  4. 0/x or x/inf: ±0, zero=1.
- Exponent: e = e1 - e2 + bias, computed as a signed EXP_W+2 value.
- Mantissas: both get the hidden bit (24 bits). Remainder starts at m1; each DIV step does rem = rem - m2 if rem ≥ m2, shifts the quotient bit in, then doubles rem.
- NORM:
  - If q[QBITS-1]=1: take q[QBITS-1:2] as the significand, g=q[1], sticky = q[0] | (rem≠0).
  - Otherwise: shift left by one, e = e - 1, sticky = (rem≠0).
- ROUND:
  - Apply the rounding mode selected by the optional feature below.
  - If the significand carries out on round-up, shift right and increment e.
  - Then if e ≥ 255: ±inf (0x7F800000 | sign), exp_overflow=1.
  - If e ≤ 0: ±0, zero=1.

Optional Feature:
FP_DIV_RNE_EN
- Defined: round to nearest, ties to even: increment when g & (sticky | lsb).
- Undefined: truncate, ignoring g and sticky. This matches fp_mult's rounding and lets the golden vectors be shared.
- Latency is identical in both builds; the ROUND state always exists.

Decomposition:
- Shared package fp_pkg:
  - EXP_W, MAN_W, BIAS, QNAN (0x7FC00000), POS_INF constants.
  - fp_t packed struct {sign, exp, frac}.
  - fp_class_e enum {ZERO, NORMAL, INF, NAN}.
  - div_state_e enum.
- Sub-module fp_classify: combinational operand decoder producing class and significand. It is reusable by fp_mult.
- Datapath and FSM live in fp_div_seq.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), start pulsed once: done exactly 28 cycles later, res=0x40400000, all flags 0, busy high for 28 cycles.
- 0x3F800000 / 0x40400000 (1/3): res=0x3EAAAAAB with FP_DIV_RNE_EN defined, 0x3EAAAAAA without.
- 0x3F800000 / 0x00000000: done after 2 cycles, res=0x7F800000, div_by_zero=1. 0x00000000/0x00000000: res=0x7FC00000, nan=1.
- 0x7F000000 / 0x3E800000: res=0x7F800000, exp_overflow=1. 0x00800000 / 0x40000000: res=0x00000000, zero=1 (underflow flush).
- Accept 6/2, hold start high with other operands for 10 cycles: only one done, res=0x40400000.
- Repeat 6/2 but assert rst_n=0 at cycle 12: outputs clear immediately, no done. After release, 0xC0C00000/0x40000000 yields 0xC0400000.
